// File: rtl/dyn_phase_pkg.sv
// ----------------------------------------------------------------------------
// dyn_phase_pkg : shared types and constants for the PLL dynamic-phase stepper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dyn_phase_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  localparam int SEL_ALL = 0;
  localparam int SEL_M   = 1;
  localparam int SEL_C0  = 2;
  localparam int SEL_C1  = 3;
  localparam int SEL_C2  = 4;
  localparam int SEL_C3  = 5;
  localparam int SEL_C4  = 6;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dyn_phase_sync.sv
// ----------------------------------------------------------------------------
// dyn_phase_sync : generic 2-FF synchroniser with asynchronous reset to 0
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dyn_phase_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/dyn_phase_ctrl.sv
// ----------------------------------------------------------------------------
// dyn_phase_ctrl : multi-step PLL phase shifter with PHASEDONE handshake,
//                  timeout abort and signed net-position tracking
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dyn_phase_ctrl
  import dyn_phase_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int STEP_W    = 8,
  parameter int POS_W     = 16,
  parameter int PULSE_CYC = 2,
  parameter int TMO_CYC   = 1023
) (
  input  logic              CLK50M,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [CNT_W-1:0]  REQ_SEL,
  input  logic              REQ_UP,
  input  logic [STEP_W-1:0] REQ_STEPS,
  input  logic              CLR_POS,
  input  logic              PHASEDONE,
  output logic [CNT_W-1:0]  PHASECOUNTERSELECT,
  output logic              PHASEUPDOWN,
  output logic              PHASESTEP,
  output logic              BUSY,
  output logic              DONE,
  output logic              TMO_ERR,
  output logic [STEP_W-1:0] STEPS_DONE,
  output logic [POS_W-1:0]  POS
);

  // One counter times both the step pulse and the handshake timeouts.
  localparam int               TMR_W      = $clog2(max2(TMO_CYC, PULSE_CYC) + 1);
  localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TMO_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SEL_IDLE   = CNT_W'(SEL_ALL);

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0]    sel_q, sel_d;
  logic                up_q, up_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [STEP_W-1:0]   steps_done_q, steps_done_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                tmo_err_q, tmo_err_d;
  logic                done_q, done_d;
  logic                phasestep_q, phasestep_d;
  logic                step_ok;
  logic                pd_s;
  logic                accept;

  dyn_phase_sync #(
    .WIDTH (1)
  ) u_pd_sync (
    .clk_i  (CLK50M),
    .rst_ni (RESET_N),
    .d_i    (PHASEDONE),
    .q_o    (pd_s)
  );

  assign REQ_READY = (state_q == IDLE) && pd_s;
  assign accept    = REQ_VALID && REQ_READY;

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    sel_d        = sel_q;
    up_d         = up_q;
    steps_d      = steps_q;
    steps_done_d = steps_done_q;
    pos_d        = pos_q;
    tmo_err_d    = tmo_err_q;
    done_d       = 1'b0;
    step_ok      = 1'b0;

    // PLL controls fall back to idle one cycle after completion unless a
    // new request is latched in that same cycle.
    if (done_q) begin
      sel_d = SEL_IDLE;
      up_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d        = REQ_SEL;
          up_d         = REQ_UP;
          steps_d      = REQ_STEPS;
          steps_done_d = '0;
          tmo_err_d    = 1'b0;
          tmr_d        = '0;
          if (REQ_STEPS == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        state_d = PULSE;
        tmr_d   = '0;
      end

      PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          state_d = WAIT_LO;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      WAIT_LO: begin
        if (!pd_s) begin
          state_d = WAIT_HI;
          tmr_d   = '0;
        end else if (tmr_q == TMO_LAST) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      WAIT_HI: begin
        if (pd_s) begin
          step_ok      = 1'b1;
          steps_done_d = steps_done_q + STEP_W'(1);
          if (steps_done_d == steps_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end else if (tmr_q == TMO_LAST) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (CLR_POS) begin
      pos_d = '0;
    end else if (step_ok) begin
      pos_d = up_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    end

    // Registered so the PLL sees a glitch-free strobe.
    phasestep_d = (state_d == PULSE);
  end

  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      sel_q        <= SEL_IDLE;
      up_q         <= 1'b0;
      steps_q      <= '0;
      steps_done_q <= '0;
      pos_q        <= '0;
      tmo_err_q    <= 1'b0;
      done_q       <= 1'b0;
      phasestep_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      sel_q        <= sel_d;
      up_q         <= up_d;
      steps_q      <= steps_d;
      steps_done_q <= steps_done_d;
      pos_q        <= pos_d;
      tmo_err_q    <= tmo_err_d;
      done_q       <= done_d;
      phasestep_q  <= phasestep_d;
    end
  end

  assign PHASECOUNTERSELECT = sel_q;
  assign PHASEUPDOWN        = up_q;
  assign PHASESTEP          = phasestep_q;
  assign BUSY               = (state_q != IDLE);
  assign DONE               = done_q;
  assign TMO_ERR            = tmo_err_q;
  assign STEPS_DONE         = steps_done_q;
  assign POS                = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_dyn_phase_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dyn_phase_ctrl : directed bench with a cycle-level behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dyn_phase_ctrl;

  localparam int CNT_W     = 4;
  localparam int STEP_W    = 8;
  // Position width narrowed so the signed wrap boundary is reachable quickly.
  localparam int POS_W     = 8;
  localparam int PULSE_CYC = 2;
  localparam int TMO_CYC   = 1023;

  logic              CLK50M = 1'b0;
  logic              RESET_N = 1'b0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic [CNT_W-1:0]  REQ_SEL = '0;
  logic              REQ_UP = 1'b0;
  logic [STEP_W-1:0] REQ_STEPS = '0;
  logic              CLR_POS;
  logic              PHASEDONE = 1'b1;
  logic [CNT_W-1:0]  PHASECOUNTERSELECT;
  logic              PHASEUPDOWN;
  logic              PHASESTEP;
  logic              BUSY;
  logic              DONE;
  logic              TMO_ERR;
  logic [STEP_W-1:0] STEPS_DONE;
  logic [POS_W-1:0]  POS;

  logic clr_tb = 1'b0;
  logic clr_pll = 1'b0;
  logic pll_stuck = 1'b0;
  logic clr_on_done = 1'b0;
  assign CLR_POS = clr_tb | clr_pll;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int dones = 0;
  int step_hi = 0;

  dyn_phase_ctrl #(
    .CNT_W     (CNT_W),
    .STEP_W    (STEP_W),
    .POS_W     (POS_W),
    .PULSE_CYC (PULSE_CYC),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .CLK50M             (CLK50M),
    .RESET_N            (RESET_N),
    .REQ_VALID          (REQ_VALID),
    .REQ_READY          (REQ_READY),
    .REQ_SEL            (REQ_SEL),
    .REQ_UP             (REQ_UP),
    .REQ_STEPS          (REQ_STEPS),
    .CLR_POS            (CLR_POS),
    .PHASEDONE          (PHASEDONE),
    .PHASECOUNTERSELECT (PHASECOUNTERSELECT),
    .PHASEUPDOWN        (PHASEUPDOWN),
    .PHASESTEP          (PHASESTEP),
    .BUSY               (BUSY),
    .DONE               (DONE),
    .TMO_ERR            (TMO_ERR),
    .STEPS_DONE         (STEPS_DONE),
    .POS                (POS)
  );

  always #10 CLK50M = ~CLK50M;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: request timeline from accept, handshake via a delayed
  // copy of PHASEDONE, outcome bookkeeping in plain integers.
  logic             m_ps1 = 1'b0, m_ps2 = 1'b0;
  logic             m_busy = 1'b0, m_done = 1'b0, m_lo = 1'b0, m_tmo = 1'b0;
  logic             m_up = 1'b0;
  logic [CNT_W-1:0] m_sel = '0;
  logic [STEP_W-1:0] m_steps = '0, m_sd = '0;
  logic [POS_W-1:0] m_pos = '0;
  int               m_lead = 0;
  int               m_cnt = 0;

  initial begin
    logic fin, stepped;
    forever begin
      @(posedge CLK50M or negedge RESET_N);
      if (!RESET_N) begin
        m_ps1 = 0; m_ps2 = 0; m_busy = 0; m_done = 0; m_lo = 0; m_tmo = 0;
        m_up = 0; m_sel = '0; m_steps = '0; m_sd = '0; m_pos = '0;
        m_lead = 0; m_cnt = 0;
      end else begin
        fin = 1'b0;
        stepped = 1'b0;
        if (m_done) begin
          m_sel = '0;
          m_up  = 1'b0;
        end
        if (!m_busy) begin
          if (REQ_VALID && m_ps2) begin
            m_sel = REQ_SEL; m_up = REQ_UP; m_steps = REQ_STEPS;
            m_sd = '0; m_tmo = 1'b0;
            if (REQ_STEPS == 0) fin = 1'b1;
            else begin m_busy = 1'b1; m_lead = 1 + PULSE_CYC; m_cnt = 0; end
          end
        end else if (m_lead > 0) begin
          m_lead--;
        end else if (!m_lo) begin
          if (!m_ps2) begin m_lo = 1'b1; m_cnt = 0; end
          else begin
            m_cnt++;
            if (m_cnt == TMO_CYC) begin m_tmo = 1'b1; fin = 1'b1; end
          end
        end else begin
          if (m_ps2) begin
            stepped = 1'b1; m_sd++; m_lo = 1'b0; m_cnt = 0;
            if (m_sd == m_steps) fin = 1'b1;
            else m_lead = 1 + PULSE_CYC;
          end else begin
            m_cnt++;
            if (m_cnt == TMO_CYC) begin m_tmo = 1'b1; fin = 1'b1; end
          end
        end
        if (fin) begin m_busy = 1'b0; m_lo = 1'b0; m_cnt = 0; end
        m_done = fin;
        if (CLR_POS) m_pos = '0;
        else if (stepped) m_pos = m_up ? m_pos + 1'b1 : m_pos - 1'b1;
        m_ps2 = m_ps1;
        m_ps1 = PHASEDONE;
      end
    end
  end

  // Per-cycle comparison against the model, plus event counters.
  initial begin
    logic mon_prev;
    logic exp_step;
    mon_prev = 1'b0;
    forever begin
      @(negedge CLK50M);
      if (RESET_N) begin
        exp_step = m_busy && (m_lead >= 1) && (m_lead <= PULSE_CYC);
        chk("req_ready", REQ_READY, !m_busy && m_ps2);
        chk("busy", BUSY, m_busy);
        chk("done", DONE, m_done);
        chk("phasestep", PHASESTEP, exp_step);
        chk("cntsel", PHASECOUNTERSELECT, m_sel);
        chk("updown", PHASEUPDOWN, m_up);
        chk("steps_done", STEPS_DONE, m_sd);
        chk("pos", POS, m_pos);
        chk("tmo_err", TMO_ERR, m_tmo);
        if (PHASESTEP && !mon_prev) pulses++;
        if (PHASESTEP) step_hi++;
        if (DONE) dones++;
        mon_prev = PHASESTEP;
      end else begin
        mon_prev = 1'b0;
      end
    end
  end

  // PLL model: PHASEDONE drops 3 cycles after the PHASESTEP fall, rises 5 later.
  initial begin
    logic prev_step;
    prev_step = 1'b0;
    forever begin
      @(negedge CLK50M);
      if (RESET_N && prev_step && !PHASESTEP && !pll_stuck) begin
        prev_step = 1'b0;
        repeat (3) @(negedge CLK50M);
        PHASEDONE = 1'b0;
        repeat (5) @(negedge CLK50M);
        PHASEDONE = 1'b1;
        if (clr_on_done) begin
          repeat (2) @(negedge CLK50M);
          clr_pll = 1'b1;
          @(negedge CLK50M);
          clr_pll = 1'b0;
        end
      end else begin
        prev_step = PHASESTEP;
      end
    end
  end

  task automatic do_req(input logic [CNT_W-1:0] sel, input logic up, input logic [STEP_W-1:0] steps);
    int n;
    n = 0;
    while (!REQ_READY && n < 100) begin
      @(negedge CLK50M);
      n++;
    end
    chk("req_ready_wait", REQ_READY, 1'b1);
    REQ_SEL = sel; REQ_UP = up; REQ_STEPS = steps; REQ_VALID = 1'b1;
    @(negedge CLK50M);
    REQ_VALID = 1'b0;
    REQ_SEL = ~sel; REQ_UP = ~up; REQ_STEPS = 8'hAA;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (!DONE && n < budget) begin
      @(negedge CLK50M);
      n++;
    end
    chk(nm, DONE, 1'b1);
  endtask

  task automatic clear_pos();
    clr_tb = 1'b1;
    @(negedge CLK50M);
    clr_tb = 1'b0;
    chk("clr_pos", POS, 8'h00);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: run did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, h0, n;

    // Reset state
    repeat (3) @(negedge CLK50M);
    chk("rst_ready", REQ_READY, 1'b0);
    chk("rst_step", PHASESTEP, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_pos", POS, 8'h00);
    chk("rst_sel", PHASECOUNTERSELECT, 4'h0);
    RESET_N = 1'b1;
    @(negedge CLK50M);
    chk("ready_after_1", REQ_READY, 1'b0);
    @(negedge CLK50M);
    chk("ready_after_2", REQ_READY, 1'b1);

    // Single up step
    p0 = pulses; d0 = dones; h0 = step_hi;
    do_req(4'd2, 1'b1, 8'd1);
    wait_done("single_done", 100);
    chk("single_pos", POS, 8'h01);
    chk("single_sd", STEPS_DONE, 8'd1);
    chk("single_ud", PHASEUPDOWN, 1'b1);
    chk("single_sel", PHASECOUNTERSELECT, 4'd2);
    @(negedge CLK50M);
    chk("single_sel_idle", PHASECOUNTERSELECT, 4'd0);
    @(negedge CLK50M);
    chk("single_pulses", pulses - p0, 1);
    chk("single_width", step_hi - h0, PULSE_CYC);
    chk("single_dones", dones - d0, 1);

    // Multi down, with REQ_* churn while busy
    clear_pos();
    p0 = pulses; h0 = step_hi;
    do_req(4'd3, 1'b0, 8'd5);
    REQ_SEL = 4'hF; REQ_UP = 1'b1; REQ_STEPS = 8'd9; REQ_VALID = 1'b1;
    repeat (3) @(negedge CLK50M);
    REQ_VALID = 1'b0;
    wait_done("multi_done", 400);
    chk("multi_pos", POS, 8'hFB);
    chk("multi_sd", STEPS_DONE, 8'd5);
    chk("multi_sel", PHASECOUNTERSELECT, 4'd3);
    repeat (2) @(negedge CLK50M);
    chk("multi_pulses", pulses - p0, 5);
    chk("multi_width", step_hi - h0, 5 * PULSE_CYC);

    // Zero steps
    p0 = pulses;
    do_req(4'd4, 1'b1, 8'd0);
    chk("zero_done", DONE, 1'b1);
    chk("zero_busy", BUSY, 1'b0);
    chk("zero_pos", POS, 8'hFB);
    repeat (2) @(negedge CLK50M);
    chk("zero_pulses", pulses - p0, 0);

    // Timeout in WAIT_LO
    pll_stuck = 1'b1;
    p0 = pulses;
    do_req(4'd5, 1'b1, 8'd3);
    n = 0;
    while (!PHASESTEP && n < 20) begin @(negedge CLK50M); n++; end
    chk("tmo_saw_step", PHASESTEP, 1'b1);
    n = 0;
    while (PHASESTEP && n < 20) begin @(negedge CLK50M); n++; end
    n = 0;
    while (!DONE && n < 3000) begin n++; @(negedge CLK50M); end
    chk("tmo_wait_cycles", n, TMO_CYC);
    chk("tmo_err", TMO_ERR, 1'b1);
    chk("tmo_sd", STEPS_DONE, 8'd0);
    chk("tmo_pos", POS, 8'hFB);
    chk("tmo_pulses", pulses - p0, 1);
    pll_stuck = 1'b0;
    @(negedge CLK50M);
    do_req(4'd2, 1'b1, 8'd1);
    chk("tmo_cleared", TMO_ERR, 1'b0);
    wait_done("after_tmo_done", 100);
    chk("after_tmo_pos", POS, 8'hFC);

    // Wrap and coincident clear
    @(negedge CLK50M);
    clear_pos();
    do_req(4'd2, 1'b1, 8'd127);
    wait_done("wrap_fill_done", 4000);
    chk("wrap_max", POS, 8'h7F);
    @(negedge CLK50M);
    do_req(4'd2, 1'b1, 8'd1);
    wait_done("wrap_done", 100);
    chk("wrap_min", POS, 8'h80);
    clr_on_done = 1'b1;
    @(negedge CLK50M);
    do_req(4'd6, 1'b1, 8'd1);
    wait_done("clr_coinc_done", 100);
    chk("clr_coinc_pos", POS, 8'h00);
    chk("clr_coinc_sd", STEPS_DONE, 8'd1);
    clr_on_done = 1'b0;

    // Reset during PULSE
    @(negedge CLK50M);
    do_req(4'd6, 1'b1, 8'd2);
    n = 0;
    while (!PHASESTEP && n < 20) begin @(negedge CLK50M); n++; end
    chk("rst_saw_step", PHASESTEP, 1'b1);
    d0 = dones;
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_mid_step", PHASESTEP, 1'b0);
    chk("rst_mid_busy", BUSY, 1'b0);
    chk("rst_mid_done", DONE, 1'b0);
    repeat (3) @(negedge CLK50M);
    RESET_N = 1'b1;
    n = 0;
    do begin
      @(negedge CLK50M);
      n++;
    end while (!REQ_READY && n < 10);
    chk("rst_ready_lat", n, 2);
    chk("rst_no_done", dones - d0, 0);
    repeat (2) @(negedge CLK50M);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
